// File: rtl/line_memory_ctrl.sv
// line_memory_ctrl: backing main-memory model behind the data cache.
// Services one 128-bit line read or write at a time. The response appears a
// fixed LATENCY cycles after the request is accepted. Out-of-range addresses
// are reported as a memory error.
//
// Ports:
//   clock, reset               system clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_write                  1 = line write, 0 = line read
//   req_addr                   byte address; line index = req_addr[IDX_W+3:4]
//   req_wdata                  write line, word0 in [31:0]
//   resp_valid/resp_ready      response handshake
//   resp_rdata                 read line; 0 for writes and errors
//   resp_err                   address was out of range
//   busy                       controller is not idle
module line_memory_ctrl #(
   parameter int unsigned LINES   = 1024,
   parameter int unsigned IDX_W   = 10,
   parameter int unsigned LATENCY = 5
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic           req_write,
   input  logic [31:0]    req_addr,
   input  logic [127:0]   req_wdata,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic [127:0]   resp_rdata,
   output logic           resp_err,
   output logic           busy
);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               write_q, write_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [127:0]       wdata_q, wdata_d;
   logic               err_q, err_d;
   logic [127:0]       rdata_q, rdata_d;
   logic               resp_err_q, resp_err_d;

   // Storage; deliberately not reset so preloaded contents survive reset.
   logic [127:0]       memArray [LINES];

   logic               accept;
   logic               commit;
   logic               resp_hs;
   logic               unused_addr_bits;

   assign unused_addr_bits = ^req_addr[3:0];

   assign accept  = req_valid && (state_q == StIdle);
   assign resp_hs = resp_ready && (state_q == StResp);
   // The counter runs down to zero in WAIT; the edge seen with zero enters RESP,
   // which puts resp_valid exactly LATENCY edges after the accepting edge.
   assign commit  = (state_q == StWait) && (cnt_q == 4'd0);

   // State register and datapath flops
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         write_q    <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         resp_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         write_q    <= write_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         resp_err_q <= resp_err_d;
      end
   end

   // Write commits on the edge entering RESP; reset suppresses a pending write.
   always_ff @(posedge clock) begin
      if (!reset && commit && write_q && !err_q) begin
         memArray[idx_q] <= wdata_q;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StWait;
         StWait:  if (commit) state_d = StResp;
         StResp:  if (resp_hs) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state
   always_comb begin
      cnt_d      = cnt_q;
      write_d    = write_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      resp_err_d = resp_err_q;

      if (accept) begin
         cnt_d   = 4'(LATENCY - 1);
         write_d = req_write;
         idx_d   = req_addr[IDX_W+3:4];
         wdata_d = req_wdata;
         err_d   = (req_addr[31:IDX_W+4] != '0);
      end else if (state_q == StWait && cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end

      if (commit) begin
         rdata_d    = (!write_q && !err_q) ? memArray[idx_q] : '0;
         resp_err_d = err_q;
      end else if (resp_hs) begin
         rdata_d    = '0;
         resp_err_d = 1'b0;
      end
   end

   // Outputs
   always_comb begin
      req_ready  = (state_q == StIdle);
      resp_valid = (state_q == StResp);
      busy       = (state_q != StIdle);
      resp_rdata = rdata_q;
      resp_err   = resp_err_q;
   end

endmodule

// File: tb/tb_line_memory_ctrl.sv
// Directed bench for line_memory_ctrl: a LATENCY=5 instance for the main
// scenarios and a LATENCY=2 instance for the short-latency case.
module tb_line_memory_ctrl;

   localparam int LAT = 5;
   localparam logic [127:0] P3 = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
   localparam logic [127:0] P5 = 128'h5555_0003_5555_0002_5555_0001_5555_0000;
   localparam logic [127:0] P7 = 128'h7777_0003_7777_0002_7777_0001_7777_0000;
   localparam logic [127:0] P9 = 128'h9999_0003_9999_0002_9999_0001_9999_0000;
   localparam logic [127:0] W0 = 128'hAAAA_0003_BBBB_0002_CCCC_0001_0000_000F;
   localparam logic [127:0] JUNK = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic         reset, req_valid, req_write, resp_ready;
   logic [31:0]  req_addr;
   logic [127:0] req_wdata;
   logic         req_ready, resp_valid, resp_err, busy;
   logic [127:0] resp_rdata;

   logic         reset2, req_valid2, req_write2, resp_ready2;
   logic [31:0]  req_addr2;
   logic [127:0] req_wdata2;
   logic         req_ready2, resp_valid2, resp_err2, busy2;
   logic [127:0] resp_rdata2;

   int n_tests = 0;
   int n_fail  = 0;

   line_memory_ctrl #(.LINES(1024), .IDX_W(10), .LATENCY(LAT)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .busy       (busy)
   );

   line_memory_ctrl #(.LINES(1024), .IDX_W(10), .LATENCY(2)) dut2 (
      .clock      (clock),
      .reset      (reset2),
      .req_valid  (req_valid2),
      .req_ready  (req_ready2),
      .req_write  (req_write2),
      .req_addr   (req_addr2),
      .req_wdata  (req_wdata2),
      .resp_valid (resp_valid2),
      .resp_ready (resp_ready2),
      .resp_rdata (resp_rdata2),
      .resp_err   (resp_err2),
      .busy       (busy2)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one request on dut and return at the negedge where resp_valid is seen.
   // With toggle set, req_valid flips against other lines while the request waits.
   task automatic run_req(input logic wr, input logic [31:0] addr, input logic [127:0] wd,
                          input bit toggle);
      int k;
      @(negedge clock);
      check("req_ready_idle", 128'(req_ready), 128'(1));
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      k = 0;
      while (!resp_valid && k < 20) begin
         if (toggle) begin
            req_valid = (k % 2 == 0);
            req_write = 1'b1;
            req_addr  = 32'h90 + 32'(k % 3) * 32'h10;
            req_wdata = JUNK;
         end
         @(negedge clock);
         k++;
      end
      req_valid = 1'b0;
      check("latency", 128'(k), 128'(LAT));
   endtask

   task automatic close_resp();
      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
      check("hs_valid_low", 128'(resp_valid), 128'(0));
      check("hs_err_low", 128'(resp_err), 128'(0));
      check("hs_ready_high", 128'(req_ready), 128'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b0;
      req_addr = '0; req_wdata = '0;
      reset2 = 1'b1; req_valid2 = 1'b0; req_write2 = 1'b0; resp_ready2 = 1'b0;
      req_addr2 = '0; req_wdata2 = '0;
      dut.memArray[3]  = P3;
      dut.memArray[5]  = P5;
      dut.memArray[7]  = P7;
      dut.memArray[9]  = P9;
      dut2.memArray[3] = P3;
      dut2.memArray[5] = P5;

      repeat (2) @(negedge clock);
      check("rst_req_ready", 128'(req_ready), 128'(1));
      check("rst_resp_valid", 128'(resp_valid), 128'(0));
      check("rst_rdata", resp_rdata, 128'(0));
      check("rst_err", 128'(resp_err), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      reset = 1'b0;
      reset2 = 1'b0;

      // Read of line 3 with ignored requests toggling during WAIT
      run_req(1'b0, 32'h30, '0, 1'b1);
      check("rd3_data", resp_rdata, P3);
      check("rd3_err", 128'(resp_err), 128'(0));
      check("rd3_busy", 128'(busy), 128'(1));
      close_resp();
      check("ignored_no_write9", dut.memArray[9], P9);
      check("ignored_no_write10", dut.memArray[10][31:0] == 32'hDEADBEEF ? 128'(1) : 128'(0),
            128'(0));

      // Write line 0 then read it back through another byte offset
      run_req(1'b1, 32'h00, W0, 1'b0);
      check("wr0_rdata", resp_rdata, 128'(0));
      check("wr0_err", 128'(resp_err), 128'(0));
      close_resp();
      check("wr0_mem", dut.memArray[0], W0);
      check("wr0_word0", 128'(dut.memArray[0][31:0]), 128'(15));
      run_req(1'b0, 32'h0C, '0, 1'b0);
      check("raw_data", resp_rdata, W0);
      close_resp();

      // Backpressure with a competing request held high
      run_req(1'b0, 32'h30, '0, 1'b0);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h50; req_wdata = JUNK;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("bp_valid", 128'(resp_valid), 128'(1));
         check("bp_data", resp_rdata, P3);
         check("bp_err", 128'(resp_err), 128'(0));
         check("bp_req_ready", 128'(req_ready), 128'(0));
      end
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      close_resp();
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("bp_single_hs", 128'(resp_valid), 128'(0));
         check("bp_idle", 128'(busy), 128'(0));
      end
      check("bp_no_write5", dut.memArray[5], P5);

      // Out-of-range write (index bits alias line 0)
      run_req(1'b1, 32'h0000_4000, JUNK, 1'b0);
      check("oor_err", 128'(resp_err), 128'(1));
      check("oor_rdata", resp_rdata, 128'(0));
      close_resp();
      check("oor_mem0", dut.memArray[0], W0);
      check("oor_mem3", dut.memArray[3], P3);
      run_req(1'b0, 32'h30, '0, 1'b0);
      check("post_oor_data", resp_rdata, P3);
      check("post_oor_err", 128'(resp_err), 128'(0));
      close_resp();

      // Reset two cycles into a write of line 7
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h70; req_wdata = JUNK;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("midrst_ready", 128'(req_ready), 128'(1));
      check("midrst_valid", 128'(resp_valid), 128'(0));
      check("midrst_busy", 128'(busy), 128'(0));
      reset = 1'b0;
      repeat (8) @(negedge clock);
      check("midrst_no_resp", 128'(resp_valid), 128'(0));
      check("midrst_mem7", dut.memArray[7], P7);

      // Reset while a response is held drops it
      run_req(1'b0, 32'h30, '0, 1'b0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("rsprst_valid", 128'(resp_valid), 128'(0));
      check("rsprst_rdata", resp_rdata, 128'(0));

      // LATENCY=2 instance with toggling requests during WAIT
      @(negedge clock);
      req_valid2 = 1'b1; req_write2 = 1'b0; req_addr2 = 32'h30;
      @(posedge clock);
      @(negedge clock);
      req_valid2 = 1'b1; req_write2 = 1'b1; req_addr2 = 32'h50; req_wdata2 = JUNK;
      k = 0;
      while (!resp_valid2 && k < 20) begin
         @(negedge clock);
         k++;
         req_valid2 = ~req_valid2;
         req_addr2  = req_addr2 + 32'h10;
      end
      req_valid2 = 1'b0; req_write2 = 1'b0;
      check("lat2_latency", 128'(k), 128'(2));
      check("lat2_data", resp_rdata2, P3);
      resp_ready2 = 1'b1;
      @(negedge clock);
      resp_ready2 = 1'b0;
      check("lat2_hs_valid", 128'(resp_valid2), 128'(0));
      check("lat2_no_write5", dut2.memArray[5], P5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
